seq_rshifter32: RTL and testbench
=================================

SEQ_RSHIFTER32 -- requirements
Module: seq_rshifter32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width (a power of two, at least 2).
REQ-002 The block SHALL have localparam SHW = log2(WIDTH), default 5, giving the shift-amount width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 in_data  input  WIDTH  operand to shift right.
REQ-008 in_shamt  input  SHW  shift amount, 0..WIDTH-1.
REQ-009 in_arith  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill).
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_data  output  WIDTH  shifted result.
REQ-013 out_zero  output  1  out_data == 0; meaningful only while out_valid = 1.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, SHIFT and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 On an edge in IDLE with in_valid = 1, the block SHALL latch in_data, in_shamt and in_arith, clear stage counter stg to 0 and enter SHIFT.
REQ-017 In SHIFT, each edge SHALL shift the working register right by 2^stg if bit stg of the latched shamt is 1 (pass-through otherwise), then increment stg.
REQ-018 Vacated MSBs SHALL be filled with the latched original bit WIDTH-1 when arith = 1, and with 0 otherwise.
REQ-019 On the edge that processes stg = SHW-1, the block SHALL enter DONE.
REQ-020 Latency SHALL be fixed: out_valid rises exactly SHW edges (5 at default) after the accept edge, for every shamt including 0.
REQ-021 In DONE, out_data and out_zero SHALL hold stable until an edge with out_ready = 1, which SHALL return the FSM to IDLE.
REQ-022 The block SHALL not accept a new request in the same edge as a result handoff; the next accept occurs at the earliest one edge after returning to IDLE.
REQ-023 in_data, in_shamt and in_arith SHALL be ignored outside IDLE, and input changes during SHIFT or DONE SHALL not affect the result.
REQ-024 out_data SHALL be registered, with no combinational path from any input to out_data or out_zero.
REQ-025 Throughput SHALL be one result per SHW+2 cycles when out_ready is held at 1.

Reset
REQ-026 While rst = 1, the state SHALL be IDLE, stg = 0, the working register = 0, out_data = 0, out_zero = 0, out_valid = 0 and in_ready = 1, taking effect asynchronously.
REQ-027 Assertion of rst during SHIFT or DONE SHALL discard the operation without producing a result.
REQ-028 The first accept after rst deasserts SHALL be possible on the first rising edge.

Structure
REQ-029 The state encodings (IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2) and the default WIDTH and SHW SHALL live in shared package shifter_pkg.
REQ-030 The per-stage shift SHALL be a combinational sub-module rshift_stage (inputs: data, amount-select, stage index, fill bit; output: data), instantiated once and driven by stg.

Verification
REQ-031 Logical shift: 0x80000000, shamt 5, arith 0 -> out_data 0x04000000, out_zero 0, out_valid 5 edges after accept.
REQ-032 Arithmetic shift: 0x80000000, shamt 4, arith 1 -> 0xF8000000; and 0x7FFFFFFF, shamt 31, arith 1 -> 0x00000000, out_zero 1.
REQ-033 Boundaries: 0x12345678, shamt 0 -> 0x12345678 with latency still 5; 0xFFFFFFFF, shamt 31, arith 0 -> 0x00000001.
REQ-034 Backpressure: out_ready held 0 for 3 cycles in DONE -> out_data stable and in_ready 0 throughout; handoff on the 4th edge, then in_ready 1.
REQ-035 Input churn: in_data changed every cycle during SHIFT -> result matches the latched operand.
REQ-036 Reset mid-op: rst pulsed at stg = 2 -> out_valid 0 and in_ready 1 immediately; a new request afterwards yields the correct result.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared encodings and default widths for the sequential right shifter
package shifter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SHW   = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/rshift_stage.sv
// rtl/rshift_stage.sv - one binary-weighted right-shift stage (shift by 2^stage when selected)
module rshift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic             sel,
    input  logic [SHW-1:0]   stage,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    logic [SHW:0]       amt;
    logic [2*WIDTH-1:0] ext;

    // Extend with the fill bit above the operand so shifted-in MSBs come from fill
    always_comb begin
        amt = '0;
        if (sel) begin
            amt = (SHW + 1)'(1) << stage;
        end
        ext    = {{WIDTH{fill}}, data} >> amt;
        result = ext[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_rshifter32.sv
// rtl/seq_rshifter32.sv - fixed-latency sequential barrel right shifter with valid/ready handshakes
module seq_rshifter32
    import shifter_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [SHW-1:0] LAST_STG = SHW'(SHW - 1);

    state_t           state;
    logic [SHW-1:0]   stg;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   shamt_q;
    logic             fill_q;
    logic [WIDTH-1:0] stage_out;

    // Single shared stage; stg walks it through every bit of the latched shift amount
    rshift_stage #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_stage (
        .data   (work),
        .sel    (shamt_q[stg]),
        .stage  (stg),
        .fill   (fill_q),
        .result (stage_out)
    );

    // Control FSM: accept in IDLE, always run all SHW stages, hold result in DONE until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stg       <= '0;
            work      <= '0;
            shamt_q   <= '0;
            fill_q    <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        shamt_q  <= in_shamt;
                        fill_q   <= in_arith & in_data[WIDTH-1];
                        stg      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= stage_out;
                    stg  <= stg + 1'b1;
                    if (stg == LAST_STG) begin
                        out_data  <= stage_out;
                        out_zero  <= (stage_out == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_rshifter32.sv
// tb/tb_seq_rshifter32.sv - directed self-checking bench for seq_rshifter32
module tb_seq_rshifter32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;

    int tests_run;
    int tests_failed;

    seq_rshifter32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request in IDLE, pass the accept edge, then count edges until out_valid
    task automatic do_op(input logic [31:0] d, input logic [4:0] sh, input logic ar,
                         output int lat, output logic [31:0] res, output logic zro);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = sh;
        in_arith = ar;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = out_data;
        zro = out_zero;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        tests_run++;
        if (out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_out_data got %h want 00000000", out_data);
        end
        tests_run++;
        if (out_zero !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_zero got %b want 0", out_zero);
        end
    endtask

    task automatic test_logical();
        int lat; logic [31:0] res; logic zro;
        do_op(32'h8000_0000, 5'd5, 1'b0, lat, res, zro);
        tests_run++;
        if (lat !== 5) begin
            tests_failed++;
            $display("FAIL logical_latency got %0d want 5", lat);
        end
        tests_run++;
        if (res !== 32'h0400_0000) begin
            tests_failed++;
            $display("FAIL logical_data got %h want 04000000", res);
        end
        tests_run++;
        if (zro !== 1'b0) begin
            tests_failed++;
            $display("FAIL logical_zero got %b want 0", zro);
        end
        handoff();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL logical_handoff got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_arith();
        int lat; logic [31:0] res; logic zro;
        do_op(32'h8000_0000, 5'd4, 1'b1, lat, res, zro);
        tests_run++;
        if (res !== 32'hF800_0000) begin
            tests_failed++;
            $display("FAIL arith_neg_data got %h want f8000000", res);
        end
        handoff();
        do_op(32'h7FFF_FFFF, 5'd31, 1'b1, lat, res, zro);
        tests_run++;
        if (res !== 32'h0) begin
            tests_failed++;
            $display("FAIL arith_pos31_data got %h want 00000000", res);
        end
        tests_run++;
        if (zro !== 1'b1) begin
            tests_failed++;
            $display("FAIL arith_pos31_zero got %b want 1", zro);
        end
        handoff();
    endtask

    task automatic test_boundary();
        int lat; logic [31:0] res; logic zro;
        do_op(32'h1234_5678, 5'd0, 1'b1, lat, res, zro);
        tests_run++;
        if (res !== 32'h1234_5678) begin
            tests_failed++;
            $display("FAIL shamt0_data got %h want 12345678", res);
        end
        tests_run++;
        if (lat !== 5) begin
            tests_failed++;
            $display("FAIL shamt0_latency got %0d want 5", lat);
        end
        handoff();
        do_op(32'hFFFF_FFFF, 5'd31, 1'b0, lat, res, zro);
        tests_run++;
        if (res !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL shamt31_logical got %h want 00000001", res);
        end
        handoff();
    endtask

    task automatic test_backpressure();
        int lat; logic [31:0] res; logic zro;
        do_op(32'hDEAD_BEEF, 5'd12, 1'b1, lat, res, zro);
        tests_run++;
        if (res !== 32'hFFFD_EADB) begin
            tests_failed++;
            $display("FAIL bp_data got %h want fffdeadb", res);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_data !== 32'hFFFD_EADB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d got data=%h valid=%b ready=%b want data=fffdeadb valid=1 ready=0",
                         i, out_data, out_valid, in_ready);
            end
        end
        handoff();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_churn();
        int lat;
        in_valid = 1'b1;
        in_data  = 32'hA5A5_A5A5;
        in_shamt = 5'd8;
        in_arith = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_data  = $urandom;
            in_shamt = 5'($urandom_range(0, 31));
            in_arith = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        tests_run++;
        if (out_data !== 32'hFFA5_A5A5 || lat !== 5) begin
            tests_failed++;
            $display("FAIL churn_data got %h lat %0d want ffa5a5a5 lat 5", out_data, lat);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int edges; logic seen_ready; logic [31:0] first_res;
        in_valid  = 1'b1;
        in_data   = 32'hF0F0_F0F0;
        in_shamt  = 5'd1;
        in_arith  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        edges = 0;
        seen_ready = 1'b0;
        first_res = 32'h0;
        while (!(seen_ready && !in_ready) && edges < 30) begin
            if (out_valid) first_res = out_data;
            @(posedge clk); #1;
            edges++;
            if (in_ready) seen_ready = 1'b1;
        end
        in_valid  = 1'b0;
        tests_run++;
        if (edges !== 7) begin
            tests_failed++;
            $display("FAIL b2b_period got %0d want 7", edges);
        end
        tests_run++;
        if (first_res !== 32'h7878_7878) begin
            tests_failed++;
            $display("FAIL b2b_first_data got %h want 78787878", first_res);
        end
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        tests_run++;
        if (out_data !== 32'h7878_7878 || edges !== 5) begin
            tests_failed++;
            $display("FAIL b2b_second got %h lat %0d want 78787878 lat 5", out_data, edges);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] res; logic zro; logic any_valid;
        in_valid = 1'b1;
        in_data  = 32'h8000_0001;
        in_shamt = 5'd3;
        in_arith = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_async got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready);
        end
        #1;
        rst = 1'b0;
        any_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) any_valid = 1'b1;
        end
        tests_run++;
        if (any_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_discard got valid seen=%b want 0", any_valid);
        end
        do_op(32'h0000_FF00, 5'd8, 1'b0, lat, res, zro);
        tests_run++;
        if (res !== 32'h0000_00FF || lat !== 5) begin
            tests_failed++;
            $display("FAIL midrst_after got %h lat %0d want 000000ff lat 5", res, lat);
        end
        handoff();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_shamt  = 5'd0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        test_reset();
        rst = 1'b0;
        test_logical();
        test_arith();
        test_boundary();
        test_backpressure();
        test_churn();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
